// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg
// Shared definitions for the RAM arbiter slice: default RAM geometry,
// the numeric identity of each requester port, and the layout of the
// read-tracking tag that follows every launched command down the
// return pipeline.
// No ports (package).
package ram_arbiter_pkg;

  localparam int ADDR_W_DEFAULT = 15;
  localparam int DATA_W_DEFAULT = 8;

  // Port 0 is the instruction fetch front-end, port 1 the load/store unit.
  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

  // One tag per launched command: rd marks a read that expects return
  // data, port records which requester owns that data.
  typedef struct packed {
    logic rd;
    logic port;
  } tag_t;

  localparam tag_t TAG_IDLE = '{rd: 1'b0, port: PORT_FETCH};

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// rr_arb2
// Two-way grant logic with a one-bit priority pointer. In round-robin
// mode the port that was not granted most recently wins a contention;
// in fixed mode port 0 always wins. Grants are combinational so a
// requester can be accepted in the same cycle it asks.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   req0, req1  : request from port 0 / port 1
//   gnt0, gnt1  : one-hot-or-zero grant, only asserted with its request
module rr_arb2
  import ram_arbiter_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  logic prio;

  // Resolve the grant. A sole requester always wins; with both asking,
  // the pointer (or port 0 in fixed mode) breaks the tie.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (FIXED_PRIO != 0) begin
      gnt0 = req0;
      gnt1 = req1 & ~req0;
    end else if (req0 && req1) begin
      gnt0 = (prio == PORT_FETCH);
      gnt1 = (prio == PORT_DATA);
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
  end

  // The pointer names the port that wins the next contention. It only
  // moves when somebody is granted, and then points at the other port.
  // Reset leaves port 0 holding the first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio <= PORT_FETCH;
    end else if (gnt0) begin
      prio <= PORT_DATA;
    end else if (gnt1) begin
      prio <= PORT_FETCH;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter
// Shares one single-port synchronous RAM between the fetch port (0) and
// the load/store port (1). One access is accepted per cycle; the winning
// port's command is registered onto the RAM pins, and a two-stage tag
// pipeline follows reads so that the returned byte is steered back to
// its owner with a single-cycle rvalid pulse three cycles after grant.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   req0/we0/addr0/wdata0         : port 0 request, write flag, address, data
//   gnt0, rvalid0                 : port 0 accept (comb), read valid (reg)
//   req1/we1/addr1/wdata1         : port 1 equivalents
//   gnt1, rvalid1                 : port 1 accept (comb), read valid (reg)
//   rdata                         : shared registered read data
//   ram_address/ram_datain        : registered RAM address / write data
//   ram_we/ram_re                 : registered RAM write / read strobes
//   ram_dataout                   : RAM read data, valid one cycle after re
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEFAULT,
  parameter int DATA_W     = DATA_W_DEFAULT,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_datain,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [DATA_W-1:0] ram_dataout
);

  logic              grant;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  tag_t              next_tag;
  tag_t              stage1;
  tag_t              stage2;

  rr_arb2 #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_arb (
    .clk  (clk),
    .rst  (rst),
    .req0 (req0),
    .req1 (req1),
    .gnt0 (gnt0),
    .gnt1 (gnt1)
  );

  // Pick the command fields of whichever port won. When nobody is
  // granted the selection is don't-care because nothing is launched,
  // and the tag going into the pipeline is idle.
  always_comb begin
    grant     = gnt0 | gnt1;
    sel_we    = gnt1 ? we1    : we0;
    sel_addr  = gnt1 ? addr1  : addr0;
    sel_wdata = gnt1 ? wdata1 : wdata0;
    next_tag  = TAG_IDLE;
    if (grant) begin
      next_tag = '{rd: ~sel_we, port: (gnt1 ? PORT_DATA : PORT_FETCH)};
    end
  end

  // Launch the granted access onto the RAM pins. Strobes are single-cycle
  // and drop back to zero on idle cycles, while address and write data
  // simply hold so the RAM inputs do not toggle needlessly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_address <= '0;
      ram_datain  <= '0;
      ram_we      <= 1'b0;
      ram_re      <= 1'b0;
    end else begin
      ram_we <= 1'b0;
      ram_re <= 1'b0;
      if (grant) begin
        ram_address <= sel_addr;
        ram_datain  <= sel_wdata;
        ram_we      <= sel_we;
        ram_re      <= ~sel_we;
      end
    end
  end

  // Tag pipeline. Stage 1 lines up with the cycle the command sits on the
  // RAM pins, stage 2 with the cycle the RAM drives its read data. Reset
  // empties both so that no stale read is ever answered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage1 <= TAG_IDLE;
      stage2 <= TAG_IDLE;
    end else begin
      stage1 <= next_tag;
      stage2 <= stage1;
    end
  end

  // Capture the RAM output for a tracked read and pulse the owner's
  // rvalid for one cycle. rdata is only loaded by a real read, so it keeps
  // the last returned value between responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata   <= '0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      rvalid0 <= stage2.rd & (stage2.port == PORT_FETCH);
      rvalid1 <= stage2.rd & (stage2.port == PORT_DATA);
      if (stage2.rd) begin
        rdata <= ram_dataout;
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
// Bench for ram_arbiter. Drives a round-robin instance backed by a
// behavioural synchronous RAM, plus a fixed-priority instance on the same
// inputs whose grants are checked against the fixed-priority rule.
// A reference model works at the transaction level: it decides grants
// from the arbitration rules, applies accesses to its own memory array in
// grant order, and schedules each read's data three cycles after grant.
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  localparam int AW    = 15;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_datain;
  logic          ram_we, ram_re;
  logic [DW-1:0] ram_dataout;

  logic          fx_gnt0, fx_gnt1, fx_rvalid0, fx_rvalid1;
  logic [DW-1:0] fx_rdata;
  logic [AW-1:0] fx_ram_address;
  logic [DW-1:0] fx_ram_datain;
  logic          fx_ram_we, fx_ram_re;
  logic [DW-1:0] fx_ram_dataout;

  assign fx_ram_dataout = '0;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(0)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1),
    .rdata(rdata),
    .ram_address(ram_address), .ram_datain(ram_datain),
    .ram_we(ram_we), .ram_re(ram_re), .ram_dataout(ram_dataout)
  );

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1)) dut_fixed (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(fx_gnt0), .rvalid0(fx_rvalid0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(fx_gnt1), .rvalid1(fx_rvalid1),
    .rdata(fx_rdata),
    .ram_address(fx_ram_address), .ram_datain(fx_ram_datain),
    .ram_we(fx_ram_we), .ram_re(fx_ram_re), .ram_dataout(fx_ram_dataout)
  );

  function automatic logic [DW-1:0] initVal(int i);
    return DW'(i + 1);
  endfunction

  // Behavioural RAM: write and read both act on the clock edge where the
  // strobe is sampled; read data appears the cycle after. Contents survive
  // reset; init_mem preloads them once at the start.
  logic [DW-1:0] ram_mem [0:DEPTH-1];
  logic          init_mem;

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < DEPTH; i++) ram_mem[i] <= initVal(i);
    end else begin
      if (ram_we) ram_mem[ram_address] <= ram_datain;
      if (ram_re) ram_dataout <= ram_mem[ram_address];
    end
  end

  // Reference model state.
  logic [DW-1:0] model_mem [0:DEPTH-1];
  logic          last_port;
  logic          slot_v [8];
  logic          slot_p [8];
  logic [DW-1:0] slot_d [8];
  logic [DW-1:0] last_rd;
  logic          cmd_v, cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;
  int            cyc;
  int            passed;
  int            total;

  typedef struct {
    logic          r0;
    logic          w0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          r1;
    logic          w1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          eg0;
    logic          eg1;
    logic          erv0;
    logic          erv1;
    logic [DW-1:0] erd;
  } vec_t;

  vec_t vecs [20];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic modelReset();
    last_port = PORT_DATA;
    for (int i = 0; i < 8; i++) begin
      slot_v[i] = 1'b0;
      slot_p[i] = 1'b0;
      slot_d[i] = '0;
    end
    last_rd = '0;
    cmd_v   = 1'b0;
  endtask

  // One clock cycle: drive the inputs just after the edge, then at the
  // falling edge compare every output with the model and let the model
  // consume the access it decides is granted.
  task automatic applyStimulus(input logic r0, input logic w0, input logic [AW-1:0] a0,
                               input logic [DW-1:0] d0, input logic r1, input logic w1,
                               input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                               output logic g0, output logic g1);
    int s;
    int due;
    logic p;
    logic w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic e0, e1;
    @(posedge clk);
    #1;
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    @(negedge clk);

    s  = cyc % 8;
    e0 = slot_v[s] && (slot_p[s] == PORT_FETCH);
    e1 = slot_v[s] && (slot_p[s] == PORT_DATA);
    if (slot_v[s]) last_rd = slot_d[s];
    slot_v[s] = 1'b0;
    checkOutput("rvalid0", 32'(rvalid0), 32'(e0));
    checkOutput("rvalid1", 32'(rvalid1), 32'(e1));
    checkOutput("rdata", 32'(rdata), 32'(last_rd));
    checkOutput("ram_we", 32'(ram_we), 32'(cmd_v && cmd_we));
    checkOutput("ram_re", 32'(ram_re), 32'(cmd_v && !cmd_we));
    if (cmd_v) begin
      checkOutput("ram_address", 32'(ram_address), 32'(cmd_addr));
      checkOutput("ram_datain", 32'(ram_datain), 32'(cmd_data));
    end

    if (r0 && r1) begin
      g0 = (last_port == PORT_DATA);
      g1 = !g0;
    end else begin
      g0 = r0;
      g1 = r1;
    end
    checkOutput("gnt0", 32'(gnt0), 32'(g0));
    checkOutput("gnt1", 32'(gnt1), 32'(g1));
    checkOutput("fixed_gnt0", 32'(fx_gnt0), 32'(r0));
    checkOutput("fixed_gnt1", 32'(fx_gnt1), 32'(r1 && !r0));

    cmd_v = g0 || g1;
    if (cmd_v) begin
      p = g1;
      w = g1 ? w1 : w0;
      a = g1 ? a1 : a0;
      d = g1 ? d1 : d0;
      last_port = p;
      cmd_we    = w;
      cmd_addr  = a;
      cmd_data  = d;
      if (w) begin
        model_mem[a] = d;
      end else begin
        due = (cyc + 3) % 8;
        slot_v[due] = 1'b1;
        slot_p[due] = p;
        slot_d[due] = model_mem[a];
      end
    end
    cyc++;
  endtask

  initial begin
    logic g0, g1;
    logic p0_on, p0_we, p1_on, p1_we;
    logic [AW-1:0] p0_a, p1_a;
    logic [DW-1:0] p0_d, p1_d;

    passed = 0;
    total  = 0;
    cyc    = 0;
    rst    = 1'b1;
    init_mem = 1'b1;
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = initVal(i);
    modelReset();

    @(posedge clk);
    #1;
    init_mem = 1'b0;
    checkOutput("reset_ram_we", 32'(ram_we), 32'd0);
    checkOutput("reset_ram_re", 32'(ram_re), 32'd0);
    checkOutput("reset_rvalid", 32'({rvalid1, rvalid0}), 32'd0);
    checkOutput("reset_rdata", 32'(rdata), 32'd0);
    checkOutput("reset_ram_address", 32'(ram_address), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed table: {r0,w0,a0,d0, r1,w1,a1,d1, gnt0,gnt1, rvalid0,rvalid1,rdata}.
    // Memory preload is addr+1, so addr 0x10 starts as 0x11.
    vecs[0]  = '{1,0,15'h0000,8'h00, 0,0,15'h0000,8'h00, 1,0, 0,0,8'h00};
    vecs[1]  = '{0,0,15'h0000,8'h00, 0,0,15'h0000,8'h00, 0,0, 0,0,8'h00};
    vecs[2]  = '{0,0,15'h0000,8'h00, 0,0,15'h0000,8'h00, 0,0, 0,0,8'h00};
    vecs[3]  = '{0,0,15'h0000,8'h00, 0,0,15'h0000,8'h00, 0,0, 1,0,8'h01};
    vecs[4]  = '{0,0,15'h0000,8'h00, 1,1,15'h7FFF,8'hA5, 0,1, 0,0,8'h01};
    vecs[5]  = '{0,0,15'h0000,8'h00, 1,0,15'h7FFF,8'h00, 0,1, 0,0,8'h01};
    vecs[6]  = '{1,0,15'h0001,8'h00, 1,0,15'h0002,8'h00, 1,0, 0,0,8'h01};
    vecs[7]  = '{1,0,15'h0003,8'h00, 1,0,15'h0002,8'h00, 0,1, 0,0,8'h01};
    vecs[8]  = '{1,0,15'h0003,8'h00, 1,0,15'h0004,8'h00, 1,0, 0,1,8'hA5};
    vecs[9]  = '{1,0,15'h0005,8'h00, 1,0,15'h0004,8'h00, 0,1, 1,0,8'h02};
    vecs[10] = '{1,0,15'h0005,8'h00, 0,0,15'h0000,8'h00, 1,0, 0,1,8'h03};
    vecs[11] = '{1,0,15'h0010,8'h00, 0,0,15'h0000,8'h00, 1,0, 1,0,8'h04};
    vecs[12] = '{0,0,15'h0000,8'h00, 1,1,15'h0010,8'h22, 0,1, 0,1,8'h05};
    vecs[13] = '{0,0,15'h0000,8'h00, 0,0,15'h0000,8'h00, 0,0, 1,0,8'h06};
    vecs[14] = '{0,0,15'h0000,8'h00, 0,0,15'h0000,8'h00, 0,0, 1,0,8'h11};
    vecs[15] = '{1,0,15'h0010,8'h00, 0,0,15'h0000,8'h00, 1,0, 0,0,8'h11};
    vecs[16] = '{0,0,15'h0000,8'h00, 0,0,15'h0000,8'h00, 0,0, 0,0,8'h11};
    vecs[17] = '{0,0,15'h0000,8'h00, 0,0,15'h0000,8'h00, 0,0, 0,0,8'h11};
    vecs[18] = '{0,0,15'h0000,8'h00, 0,0,15'h0000,8'h00, 0,0, 1,0,8'h22};
    vecs[19] = '{0,0,15'h0000,8'h00, 0,0,15'h0000,8'h00, 0,0, 0,0,8'h22};

    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].r0, vecs[i].w0, vecs[i].a0, vecs[i].d0,
                    vecs[i].r1, vecs[i].w1, vecs[i].a1, vecs[i].d1, g0, g1);
      checkOutput($sformatf("vec%0d_gnt0", i), 32'(gnt0), 32'(vecs[i].eg0));
      checkOutput($sformatf("vec%0d_gnt1", i), 32'(gnt1), 32'(vecs[i].eg1));
      checkOutput($sformatf("vec%0d_rvalid0", i), 32'(rvalid0), 32'(vecs[i].erv0));
      checkOutput($sformatf("vec%0d_rvalid1", i), 32'(rvalid1), 32'(vecs[i].erv1));
      checkOutput($sformatf("vec%0d_rdata", i), 32'(rdata), 32'(vecs[i].erd));
    end

    // Reset in the cycle after a port 0 read is granted: the read must be
    // forgotten, and the pointer must favour port 0 again afterwards.
    applyStimulus(1, 0, 15'h0020, 8'h00, 0, 0, 15'h0000, 8'h00, g0, g1);
    checkOutput("pre_reset_gnt0", 32'(gnt0), 32'd1);
    @(posedge clk);
    #2;
    rst  = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    #1;
    checkOutput("async_rst_ram_re", 32'(ram_re), 32'd0);
    checkOutput("async_rst_ram_we", 32'(ram_we), 32'd0);
    checkOutput("async_rst_ram_address", 32'(ram_address), 32'd0);
    checkOutput("async_rst_ram_datain", 32'(ram_datain), 32'd0);
    checkOutput("async_rst_rvalid", 32'({rvalid1, rvalid0}), 32'd0);
    checkOutput("async_rst_rdata", 32'(rdata), 32'd0);
    modelReset();
    #1;
    rst = 1'b0;
    cyc++;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 15'h0000, 8'h00, 0, 0, 15'h0000, 8'h00, g0, g1);
    end
    applyStimulus(1, 0, 15'h0030, 8'h00, 1, 0, 15'h0031, 8'h00, g0, g1);
    checkOutput("post_reset_contention_gnt0", 32'(gnt0), 32'd1);
    checkOutput("post_reset_contention_gnt1", 32'(gnt1), 32'd0);
    applyStimulus(0, 0, 15'h0000, 8'h00, 1, 0, 15'h0031, 8'h00, g0, g1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 15'h0000, 8'h00, 0, 0, 15'h0000, 8'h00, g0, g1);
    end

    // Random traffic: each port holds its request until the model says it
    // was granted. A small address window keeps hazards frequent; the top
    // of memory is mixed in to exercise full-width addresses.
    p0_on = 0; p1_on = 0;
    p0_we = 0; p1_we = 0;
    p0_a = '0; p1_a = '0;
    p0_d = '0; p1_d = '0;
    for (int i = 0; i < 400; i++) begin
      if (!p0_on && ($urandom_range(0, 9) < 7)) begin
        p0_on = 1;
        p0_we = 1'($urandom_range(0, 2) == 0);
        p0_a  = ($urandom_range(0, 3) == 0) ? AW'(15'h7FF0 + $urandom_range(0, 15))
                                             : AW'($urandom_range(0, 15));
        p0_d  = DW'($urandom);
      end
      if (!p1_on && ($urandom_range(0, 9) < 7)) begin
        p1_on = 1;
        p1_we = 1'($urandom_range(0, 1));
        p1_a  = ($urandom_range(0, 3) == 0) ? AW'(15'h7FF0 + $urandom_range(0, 15))
                                             : AW'($urandom_range(0, 15));
        p1_d  = DW'($urandom);
      end
      applyStimulus(p0_on, p0_we, p0_a, p0_d, p1_on, p1_we, p1_a, p1_d, g0, g1);
      if (g0) p0_on = 0;
      if (g1) p1_on = 0;
    end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 15'h0000, 8'h00, 0, 0, 15'h0000, 8'h00, g0, g1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
